// File: rtl/oam_dma_pkg.sv
// rtl/oam_dma_pkg.sv - shared Game Boy constants and DMA state encoding
package oam_dma_pkg;

  // Bus ownership phases of an OAM DMA transfer
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int          OAM_LEN_DEF  = 160;

  // Source pages E0..FF alias onto work RAM at C0..DF
  function automatic logic [7:0] src_effective(input logic [7:0] src);
    return (src >= 8'hE0) ? (src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/oam_dma_reg.sv
// rtl/oam_dma_reg.sv - loadable register with synchronous active-low reset
module oam_dma_reg #(
  parameter int             W   = 8,
  parameter logic [W-1:0]   RST = '0
) (
  input  logic         i_clock,
  input  logic         i_resetn,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Hold value unless loaded; reset wins over load
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_q <= RST;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - OAM DMA engine sitting between the CPU and the memory map
import oam_dma_pkg::*;

module oam_dma #(
  parameter int          OAM_LEN = OAM_LEN_DEF,
  parameter logic [15:0] DMA_REG = DMA_REG_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wren,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  output logic [15:0] mem_addr,
  output logic        mem_wren,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  localparam logic [7:0] IDX_LAST = 8'(OAM_LEN - 1);

  dma_state_e  r_state;
  logic        w_dma_wr;
  logic        w_idx_last;
  logic [7:0]  w_src;
  logic [7:0]  w_src_eff;
  logic [7:0]  w_idx;
  logic [7:0]  w_idx_nxt;
  logic        w_idx_en;

  assign w_dma_wr   = cpu_wren && (cpu_addr == DMA_REG);
  assign w_idx_last = (w_idx == IDX_LAST);
  assign w_src_eff  = src_effective(w_src);

  // A DMA_REG write always (re)starts from byte 0; the index saturates on the last byte
  assign w_idx_en  = w_dma_wr || (r_state == ST_WRITE);
  assign w_idx_nxt = w_dma_wr ? 8'h00 : (w_idx_last ? w_idx : w_idx + 8'h01);

  oam_dma_reg #(.W(8), .RST(8'h00)) u_src (
    .i_clock  (clock),
    .i_resetn (reset),
    .i_en     (w_dma_wr),
    .i_d      (cpu_data_in),
    .o_q      (w_src)
  );

  oam_dma_reg #(.W(8), .RST(8'h00)) u_idx (
    .i_clock  (clock),
    .i_resetn (reset),
    .i_en     (w_idx_en),
    .i_d      (w_idx_nxt),
    .o_q      (w_idx)
  );

  // Transfer sequencing: one idle cycle, then READ/WRITE pairs until the last byte
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else if (w_dma_wr) begin
      r_state <= ST_START;
    end else begin
      case (r_state)
        ST_IDLE:  r_state <= ST_IDLE;
        ST_START: r_state <= ST_READ;
        ST_READ:  r_state <= ST_WRITE;
        ST_WRITE: r_state <= w_idx_last ? ST_IDLE : ST_READ;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign dma_active = (r_state != ST_IDLE);

  // Bus steering: pass-through when idle, DMA owns the bus otherwise
  always_comb begin
    mem_addr     = cpu_addr;
    mem_wren     = 1'b0;
    mem_wdata    = cpu_data_in;
    cpu_data_out = 8'hFF;
    case (r_state)
      ST_IDLE: begin
        mem_wren     = cpu_wren;
        cpu_data_out = mem_rdata;
      end
      ST_START: begin
        mem_addr  = {w_src_eff, 8'h00};
        mem_wdata = 8'h00;
      end
      ST_READ: begin
        mem_addr  = {w_src_eff, w_idx};
        mem_wdata = 8'h00;
      end
      ST_WRITE: begin
        mem_addr  = OAM_BASE + {8'h00, w_idx};
        mem_wren  = 1'b1;
        mem_wdata = mem_rdata;
      end
      default: begin
        mem_addr = cpu_addr;
      end
    endcase
    if (cpu_addr == DMA_REG) begin
      cpu_data_out = w_src;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - self-checking bench for oam_dma with a memory-map model
module tb_oam_dma;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_wren;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic [15:0] mem_addr;
  logic        mem_wren;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        dma_active;

  logic [7:0]  mem [0:65535];
  logic [23:0] wq[$];
  logic [15:0] rq[$];
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  oam_dma dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wren     (cpu_wren),
    .cpu_data_in  (cpu_data_in),
    .cpu_data_out (cpu_data_out),
    .mem_addr     (mem_addr),
    .mem_wren     (mem_wren),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .dma_active   (dma_active)
  );

  // Memory map model: synchronous write, read data one clock after the address
  always @(posedge clock) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h9B;
  endfunction

  function automatic logic [7:0] eff_page(input logic [7:0] s);
    return (s >= 8'hE0) ? (s - 8'h20) : s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_expect(input logic [7:0] s);
    logic [7:0] pg;
    pg = eff_page(s);
    wq.delete();
    rq.delete();
    for (int i = 0; i < 160; i++) begin
      rq.push_back({pg, 8'(i)});
      wq.push_back({16'hFE00 + 16'(i), pat({pg, 8'(i)})});
    end
  endtask

  task automatic run_xfer(input logic [7:0] s, input int restart_at, input logic [7:0] s2,
                          input int exp_n, input bit probe, input string tag);
    int n;
    int phase;
    int bad;
    logic [7:0]  s_fin;
    logic [23:0] w;
    logic [15:0] r;
    s_fin = s;
    load_expect(s);
    cpu_addr = 16'hFF46; cpu_wren = 1'b1; cpu_data_in = s;
    @(negedge clock);
    cpu_wren = 1'b0; cpu_addr = 16'h0000; cpu_data_in = 8'h00;
    n = 0;
    phase = 0;
    for (int k = 0; k < 2000; k++) begin
      if (!dma_active) break;
      n++;
      if (mem_wren) begin
        if (wq.size() == 0) begin
          chk({tag, " extra_write"}, 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          w = wq.pop_front();
          chk({tag, " oam_write"}, 32'({mem_addr, mem_wdata}), 32'(w));
        end
      end else if (phase > 0) begin
        if (rq.size() == 0) begin
          chk({tag, " extra_read"}, 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          r = rq.pop_front();
          chk({tag, " src_read_addr"}, 32'(mem_addr), 32'(r));
        end
      end
      phase++;
      cpu_wren = 1'b0; cpu_addr = 16'h0000; cpu_data_in = 8'h00;
      if (probe && n == 10) begin
        cpu_addr = 16'hC000;
        #1 chk({tag, " busy_read_ff"}, 32'(cpu_data_out), 32'h0000_00FF);
      end
      if (probe && n == 11) begin
        cpu_addr = 16'hC000; cpu_wren = 1'b1; cpu_data_in = 8'h77;
      end
      if (n == restart_at) begin
        cpu_addr = 16'hFF46; cpu_wren = 1'b1; cpu_data_in = s2;
        load_expect(s2);
        s_fin = s2;
        phase = 0;
      end
      @(negedge clock);
    end
    cpu_wren = 1'b0; cpu_addr = 16'h0000;
    chk({tag, " active_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, " writes_left"}, 32'(wq.size()), 32'd0);
    chk({tag, " reads_left"}, 32'(rq.size()), 32'd0);
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + 16'(i)] !== pat({eff_page(s_fin), 8'(i)})) bad++;
    chk({tag, " oam_contents_bad"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int bad;
    for (int a = 0; a < 65536; a++) mem[a] = pat(16'(a));
    mem[16'hC000] = 8'h11;
    reset = 1'b0; cpu_addr = 16'h0000; cpu_wren = 1'b0; cpu_data_in = 8'h00;
    repeat (2) @(negedge clock);

    // Reset state
    chk("rst dma_active", 32'(dma_active), 32'd0);
    chk("rst mem_wren", 32'(mem_wren), 32'd0);
    cpu_addr = 16'hFF46;
    #1 chk("rst src_read", 32'(cpu_data_out), 32'h00);
    reset = 1'b1;
    @(negedge clock);

    // Idle pass-through to FF80
    cpu_addr = 16'hFF80; cpu_wren = 1'b1; cpu_data_in = 8'h3C;
    #1;
    chk("idle mem_addr", 32'(mem_addr), 32'h0000_FF80);
    chk("idle mem_wren", 32'(mem_wren), 32'd1);
    chk("idle mem_wdata", 32'(mem_wdata), 32'h3C);
    @(negedge clock);
    cpu_wren = 1'b0;
    @(negedge clock);
    chk("idle read_ff80", 32'(cpu_data_out), 32'h3C);

    // Basic transfer from C1 with CPU accesses while busy
    run_xfer(8'hC1, -1, 8'h00, 321, 1'b1, "xfer_c1");
    chk("c000 untouched", 32'(mem[16'hC000]), 32'h11);
    cpu_addr = 16'hFF46;
    #1 chk("dma_reg readback c1", 32'(cpu_data_out), 32'hC1);
    @(negedge clock);

    // Echo source page
    run_xfer(8'hE2, -1, 8'h00, 321, 1'b0, "xfer_e2");

    // Restart at cycle 100
    run_xfer(8'hC1, 100, 8'hC3, 421, 1'b0, "restart_c3");
    cpu_addr = 16'hFF46;
    #1 chk("dma_reg readback c3", 32'(cpu_data_out), 32'hC3);
    @(negedge clock);

    // Reset 50 cycles into a transfer
    cpu_addr = 16'hFF46; cpu_wren = 1'b1; cpu_data_in = 8'hC4;
    @(negedge clock);
    cpu_wren = 1'b0; cpu_addr = 16'h0000;
    repeat (49) @(negedge clock);
    chk("mid active before reset", 32'(dma_active), 32'd1);
    reset = 1'b0; cpu_addr = 16'hFF46;
    @(negedge clock);
    chk("mid rst mem_wren", 32'(mem_wren), 32'd0);
    chk("mid rst dma_active", 32'(dma_active), 32'd0);
    chk("mid rst src_read", 32'(cpu_data_out), 32'h00);
    reset = 1'b1; cpu_addr = 16'h0000;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (mem_wren !== 1'b0 || dma_active !== 1'b0) bad++;
    end
    chk("post rst quiet", 32'(bad), 32'd0);

    // Reset beats a simultaneous DMA_REG write
    reset = 1'b0; cpu_addr = 16'hFF46; cpu_wren = 1'b1; cpu_data_in = 8'h55;
    @(negedge clock);
    cpu_wren = 1'b0;
    chk("rst prio dma_active", 32'(dma_active), 32'd0);
    #1 chk("rst prio src_read", 32'(cpu_data_out), 32'h00);
    reset = 1'b1;
    @(negedge clock);
    chk("rst prio still idle", 32'(dma_active), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
